// File: rtl/tc_timer.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a maskable irq.
// Optional clock prescaler enabled by defining TC_PRESCALE_EN.
module tc_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;
    logic        tick;

    logic        hit;
    logic [1:0]  off;
    logic        wr_ctrl, wr_preset;

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign off       = addr[3:2];
    assign wr_ctrl   = we && hit && (off == 2'd0);
    assign wr_preset = we && hit && (off == 2'd1);

    // Byte-lane bits of the address never select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

`ifdef TC_PRESCALE_EN
    logic [15:0] presc_q, presc_d;
    logic [15:0] div_q, div_d;
    logic        wr_presc;

    assign wr_presc = we && hit && (off == 2'd3);
    assign tick     = (div_q == presc_q);

    always_comb begin
        presc_d = presc_q;
        div_d   = '0;
        if (wr_presc) begin
            presc_d = wdata[15:0];
        end
        // Divider only runs while counting; any other state parks it at zero.
        if (state_q == S_CNT && ctrl_q[0] && !tick) begin
            div_d = div_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            div_q   <= '0;
        end else begin
            presc_q <= presc_d;
            div_q   <= div_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        if (wr_preset) begin
            preset_d = wdata;
        end

        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0]) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (count_q != 32'd0) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        state_d    = S_INT;
                        irq_flag_d = 1'b1;
                    end
                end
            end
            default: begin
                if (ctrl_q[2:1] == 2'b01) begin
                    irq_flag_d = 1'b0;
                    state_d    = S_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
        endcase

        // A software CTRL write overrides the FSM's EN clear and acknowledges the irq.
        if (wr_ctrl) begin
            ctrl_d     = wdata[3:0];
            irq_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                2'd0:    rdata = {28'd0, ctrl_q};
                2'd1:    rdata = preset_q;
                2'd2:    rdata = count_q;
`ifdef TC_PRESCALE_EN
                default: rdata = {16'd0, presc_q};
`else
                default: rdata = '0;
`endif
            endcase
        end
    end

    assign irq = irq_flag_q & ctrl_q[3];

endmodule
